// File: rtl/rf_wb_scheduler.sv
// Register-file writeback port arbiter with a pending-write scoreboard.
// Round-robin grant, one registered write per cycle, busy bypass on commit.
module rf_wb_scheduler #(
  parameter int NSRC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   src_valid,
  output logic [NSRC-1:0]   src_ready,
  input  logic [5*NSRC-1:0] src_addr,
  input  logic [32*NSRC-1:0] src_data,
  input  logic              sb_set_en,
  input  logic [4:0]        sb_set_addr,
  input  logic              flush,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [31:0]       pending,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   nxt_ptr;
  logic            any;
  logic [NSRC-1:0] gnt;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;
  logic [31:0]     sb_nxt;
  int              idx;

  // Scan from rr_ptr upward (mod NSRC); first valid wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!any && src_valid[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        sel      = PW'(idx);
      end
    end
  end

  assign src_ready = gnt;
  assign sel_addr  = src_addr[int'(sel)*5 +: 5];
  assign sel_data  = src_data[int'(sel)*32 +: 32];
  assign nxt_ptr   = (int'(sel) == NSRC - 1) ? '0 : sel + PW'(1);

  // Set is applied last so a newly issued dest survives flush/commit.
  always_comb begin
    sb_nxt = pending;
    if (flush) sb_nxt = '0;
    if (rf_we) sb_nxt[rf_waddr] = 1'b0;
    if (sb_set_en && sb_set_addr != 5'd0) sb_nxt[sb_set_addr] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending  <= '0;
    end else begin
      pending <= sb_nxt;
      if (any) begin
        rr_ptr   <= nxt_ptr;
        rf_we    <= (sel_addr != 5'd0);
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  assign rs_busy = pending[rs_addr] & ~(rf_we && rf_waddr == rs_addr);
  assign rt_busy = pending[rt_addr] & ~(rf_we && rf_waddr == rt_addr);

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration, write stage,
// scoreboard set/clear/flush priority and async reset.
module tb_rf_wb_scheduler;

  localparam int NSRC = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_ready;
  logic [5*NSRC-1:0] src_addr;
  logic [32*NSRC-1:0] src_data;
  logic              sb_set_en;
  logic [4:0]        sb_set_addr;
  logic              flush;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic              rs_busy;
  logic              rt_busy;
  logic [31:0]       pending;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.NSRC(NSRC)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .pending(pending),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int i, input logic [4:0] a,
                     input logic [31:0] d);
    src_addr[i*5 +: 5]   = a;
    src_data[i*32 +: 32] = d;
  endtask

  initial begin
    reset       = 1'b1;
    src_valid   = '0;
    src_addr    = '0;
    src_data    = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
    flush       = 1'b0;
    rs_addr     = '0;
    rt_addr     = '0;

    tick();
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_pend", pending, 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    reset = 1'b0;
    tick();

    // single source
    src(0, 5'd5, 32'hDEADBEEF);
    src_valid = 3'b001;
    #1 check("single_ready", 32'(src_ready), 32'd1);
    tick();
    src_valid = '0;
    #1;
    check("single_we", 32'(rf_we), 32'd1);
    check("single_waddr", 32'(rf_waddr), 32'd5);
    check("single_wdata", rf_wdata, 32'hDEADBEEF);
    check("single_idle_ready", 32'(src_ready), 32'd0);
    tick();
    check("idle_we", 32'(rf_we), 32'd0);
    check("idle_waddr_hold", 32'(rf_waddr), 32'd5);
    check("idle_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // ptr=1 now; a lone src2 request brings it back to 0
    src(2, 5'd4, 32'h44444444);
    src_valid = 3'b100;
    #1 check("wrap_ready", 32'(src_ready), 32'd4);
    tick();
    src_valid = '0;
    check("wrap_waddr", 32'(rf_waddr), 32'd4);

    // contention
    src(0, 5'd1, 32'h11111111);
    src(1, 5'd2, 32'h22222222);
    src(2, 5'd3, 32'h33333333);
    src_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1 check("cont_ready", 32'(src_ready), 32'(1 << k));
      tick();
      check("cont_we", 32'(rf_we), 32'd1);
      check("cont_waddr", 32'(rf_waddr), 32'(k + 1));
      check("cont_wdata", rf_wdata, {8{4'(k + 1)}});
    end
    src_valid = '0;
    tick();
    check("cont_end_we", 32'(rf_we), 32'd0);

    // write to $0
    src(1, 5'd0, 32'hCAFEF00D);
    src_valid = 3'b010;
    #1 check("zero_ready", 32'(src_ready), 32'd2);
    tick();
    src_valid = 3'b111;
    #1;
    check("zero_we", 32'(rf_we), 32'd0);
    check("zero_ptr2", 32'(src_ready), 32'd4);
    tick();
    src_valid = '0;
    check("zero_next_we", 32'(rf_we), 32'd1);
    check("zero_next_waddr", 32'(rf_waddr), 32'd3);

    // scoreboard
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd9;
    tick();
    sb_set_en = 1'b0;
    rs_addr   = 5'd9;
    rt_addr   = 5'd0;
    #1;
    check("sb_pend9", pending, 32'h200);
    check("sb_rs_busy", 32'(rs_busy), 32'd1);
    check("sb_rt_r0", 32'(rt_busy), 32'd0);
    src(1, 5'd9, 32'h99);
    src_valid = 3'b010;
    #1 check("ld_ready", 32'(src_ready), 32'd2);
    tick();
    src_valid = '0;
    #1;
    check("ld_we", 32'(rf_we), 32'd1);
    check("ld_waddr", 32'(rf_waddr), 32'd9);
    check("ld_bypass", 32'(rs_busy), 32'd0);
    check("ld_pend_still", pending, 32'h200);
    tick();
    check("ld_pend_clr", pending, 32'd0);
    check("ld_rs_after", 32'(rs_busy), 32'd0);
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd0;
    rs_addr     = 5'd0;
    tick();
    check("set0_ignored", pending, 32'd0);
    check("rs0_busy", 32'(rs_busy), 32'd0);

    // set and commit-clear of r9 in one cycle
    sb_set_addr = 5'd9;
    src(0, 5'd9, 32'hABC);
    src_valid = 3'b001;
    tick();
    src_valid = '0;
    rt_addr   = 5'd9;
    #1;
    check("sc_we", 32'(rf_we), 32'd1);
    check("sc_pend", pending, 32'h200);
    check("sc_rt_bypass", 32'(rt_busy), 32'd0);
    tick();
    sb_set_en = 1'b0;
    #1;
    check("sc_set_wins", pending, 32'h200);
    check("sc_rt_busy", 32'(rt_busy), 32'd1);

    // flush plus set
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd12;
    tick();
    sb_set_en = 1'b0;
    check("fl_pre", pending, 32'h1200);
    flush       = 1'b1;
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd3;
    tick();
    flush     = 1'b0;
    sb_set_en = 1'b0;
    check("fl_post", pending, 32'h8);

    // async reset mid-traffic
    src(0, 5'd7, 32'h77);
    src_valid   = 3'b001;
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd20;
    tick();
    src_valid = '0;
    sb_set_en = 1'b0;
    #1;
    check("mid_we", 32'(rf_we), 32'd1);
    check("mid_pend", pending, 32'h0010_0008);
    #2 reset = 1'b1;
    #1;
    check("ar_we", 32'(rf_we), 32'd0);
    check("ar_pend", pending, 32'd0);
    check("ar_waddr", 32'(rf_waddr), 32'd0);
    check("ar_wdata", rf_wdata, 32'd0);
    src_valid = 3'b111;
    tick();
    check("ar_hold_we", 32'(rf_we), 32'd0);
    reset = 1'b0;
    #1 check("ar_ptr0", 32'(src_ready), 32'd1);
    tick();
    src_valid = '0;
    check("ar_first_we", 32'(rf_we), 32'd1);
    check("ar_first_waddr", 32'(rf_waddr), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
